// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: register byte offsets, STATUS/IE
// bit positions and the transfer FSM state encoding.
package spi_slave_pkg;

  localparam logic [15:0] ADDR_CTRL   = 16'h0000;
  localparam logic [15:0] ADDR_MODE   = 16'h0008;
  localparam logic [15:0] ADDR_STATUS = 16'h000C;
  localparam logic [15:0] ADDR_DATA   = 16'h0010;
  localparam logic [15:0] ADDR_IE     = 16'h0014;

  localparam int ST_RX_VALID    = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_OVERRUN  = 2;
  localparam int ST_TX_UNDERRUN = 3;
  localparam int ST_BUSY        = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchroniser chain for one asynchronous SPI pin, followed by a history
// flop so rising/falling edges of the synchronised level can be flagged.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   hist_p;

  // Shift the pin through the synchroniser and remember the previous sample
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= '0;
      hist_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
      hist_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign level = sync_p[SYNC_STAGES-1];
  assign rise  = level & ~hist_p;
  assign fall  = ~level & hist_p;

endmodule

// File: rtl/spi_slave.sv
// Memory-mapped SPI slave: oversamples SCK/CS_N/MOSI in the clk domain and
// exchanges 8-bit MSB-first frames in any CPOL/CPHA mode.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rw_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  state_t      state, state_nx;
  logic        en, cpha, cpol;
  logic [3:0]  ie;
  logic        rx_valid, rx_overrun, tx_underrun, tx_full;
  logic [7:0]  tx_reg, rx_reg, shift_tx;
  logic [6:0]  shift_rx;
  logic [2:0]  bit_cnt;
  logic        pend_udr;
  logic        start, stop;

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .din(spi_sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall, wr_data[31:8]};

  // Register bus decode
  logic wr_ok, wr_ctrl, wr_mode, wr_status, wr_dat, wr_ie, rd_dat;
  assign wr_ok     = wr_en && (wr_strb == 4'b1111);
  assign wr_ctrl   = wr_ok && (rw_addr == ADDR_CTRL);
  assign wr_mode   = wr_ok && (rw_addr == ADDR_MODE);
  assign wr_status = wr_ok && (rw_addr == ADDR_STATUS);
  assign wr_dat    = wr_ok && (rw_addr == ADDR_DATA);
  assign wr_ie     = wr_ok && (rw_addr == ADDR_IE);
  assign rd_dat    = rd_en && (rw_addr == ADDR_DATA);

  // SCK edge roles for the current mode; edges only count inside a frame
  logic lead, trail, xfer, sample_ev, shift_ev, byte_done;
  logic tx_load, load_empty, pend_set, udr_set;
  assign lead      = cpol ? sck_fall : sck_rise;
  assign trail     = cpol ? sck_rise : sck_fall;
  assign xfer      = (state == S_XFER) && !stop;
  assign sample_ev = xfer && (cpha ? trail : lead);
  assign shift_ev  = xfer && (cpha ? lead : trail);
  assign byte_done = sample_ev && (bit_cnt == 3'd7);

  // With CPHA=0 the next byte is loaded on the trailing edge after the last
  // bit, before the master has committed to another byte. An empty load there
  // is only reported as underrun once the next byte really starts clocking,
  // so a frame ending cleanly never flags a spurious underrun.
  assign tx_load    = (start && !cpha) || (shift_ev && (bit_cnt == 3'd0));
  assign load_empty = tx_load && !tx_full;
  assign pend_set   = load_empty && !cpha && !start;
  assign udr_set    = (load_empty && (cpha || start)) || (sample_ev && pend_udr);

  logic [3:0] status_lo;
  assign status_lo = {tx_underrun, rx_overrun, ~tx_full, rx_valid};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next state: frame starts on CS falling while enabled, ends on CS
  // rising or when the block is disabled
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    stop     = 1'b0;
    case (state)
      S_IDLE: if (cs_fall && en) begin
        state_nx = S_XFER;
        start    = 1'b1;
      end
      S_XFER: if (cs_rise || !en) begin
        state_nx = S_IDLE;
        stop     = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Shift registers, bit counter and deferred-underrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_tx <= 8'h00;
      shift_rx <= 7'h00;
      bit_cnt  <= 3'd0;
      pend_udr <= 1'b0;
    end else begin
      if (tx_load)       shift_tx <= tx_full ? tx_reg : 8'h00;
      else if (shift_ev) shift_tx <= {shift_tx[6:0], 1'b0};

      if (sample_ev) shift_rx <= {shift_rx[5:0], mosi_s};

      if ((state != S_XFER) || stop) bit_cnt <= 3'd0;
      else if (sample_ev)             bit_cnt <= bit_cnt + 3'd1;

      if ((state != S_XFER) || stop) pend_udr <= 1'b0;
      else if (pend_set)              pend_udr <= 1'b1;
      else if (sample_ev)             pend_udr <= 1'b0;
    end
  end

  // CPU-visible registers and flags; later assignments give sets priority
  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= 1'b0;
      cpha        <= 1'b0;
      cpol        <= 1'b0;
      ie          <= 4'h0;
      tx_reg      <= 8'h00;
      tx_full     <= 1'b0;
      rx_reg      <= 8'h00;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_ctrl) en <= wr_data[0];
      if (wr_mode && (state == S_IDLE)) begin
        cpha <= wr_data[0];
        cpol <= wr_data[1];
      end
      if (wr_ie) ie <= wr_data[3:0];

      if (tx_load) tx_full <= 1'b0;
      if (wr_dat) begin
        tx_reg  <= wr_data[7:0];
        tx_full <= 1'b1;
      end

      if (rd_dat) rx_valid <= 1'b0;
      if (byte_done) begin
        rx_reg   <= {shift_rx, mosi_s};
        rx_valid <= 1'b1;
      end

      if (wr_status && wr_data[ST_RX_OVERRUN])  rx_overrun  <= 1'b0;
      if (wr_status && wr_data[ST_TX_UNDERRUN]) tx_underrun <= 1'b0;
      if (byte_done && rx_valid && !rd_dat)     rx_overrun  <= 1'b1;
      if (udr_set)                              tx_underrun <= 1'b1;

      irq <= |(status_lo & ie);
    end
  end

  // Combinational read mux
  always_comb begin
    rd_data = 32'd0;
    if (rd_en) begin
      case (rw_addr)
        ADDR_CTRL:   rd_data = {31'd0, en};
        ADDR_MODE:   rd_data = {30'd0, cpol, cpha};
        ADDR_STATUS: rd_data = {27'd0, (state == S_XFER), status_lo};
        ADDR_DATA:   rd_data = {24'd0, rx_reg};
        ADDR_IE:     rd_data = {28'd0, ie};
        default:     rd_data = 32'd0;
      endcase
    end
  end

  assign spi_miso    = (state == S_XFER) ? shift_tx[7] : 1'b0;
  assign spi_miso_oe = (state == S_XFER);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives an SPI master on the pins, accesses
// registers over the word bus and checks against a transaction-level model.
module tb_spi_slave;

  localparam logic [15:0] A_CTRL = 16'h00, A_MODE = 16'h08, A_STATUS = 16'h0C;
  localparam logic [15:0] A_DATA = 16'h10, A_IE = 16'h14;
  localparam int H = 8;  // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rw_addr = 16'h0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  wr_strb = 4'h0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  int n_checks = 0;
  int n_fail = 0;

  // Transaction-level model of the CPU-visible state
  bit         m_cpol, m_cpha, m_tx_full, m_rxv, m_ovr, m_udr;
  logic [7:0] m_tx, m_rx;
  logic [3:0] m_ie;
  bit         settled = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rw_addr(rw_addr), .wr_en(wr_en), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_data(rd_data), .spi_sck(spi_sck),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  function automatic logic [31:0] m_status();
    return {27'd0, 1'b0, m_udr, m_ovr, ~m_tx_full, m_rxv};
  endfunction

  function automatic logic m_irq();
    return |({m_udr, m_ovr, ~m_tx_full, m_rxv} & m_ie);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Between transactions: no frame in progress, irq tracks the model
  always @(negedge clk) begin
    if (settled) begin
      n_checks++;
      if ({irq, spi_miso_oe, spi_miso} !== {m_irq(), 2'b00}) begin
        n_fail++;
        $display("FAIL idle_outputs: irq/oe/miso got %b expected %b",
                 {irq, spi_miso_oe, spi_miso}, {m_irq(), 2'b00});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    wait_clk(3);
    settled = 1'b1;
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [31:0] d);
    settled = 1'b0;
    @(negedge clk);
    rw_addr = a; wr_data = d; wr_strb = 4'hF; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; wr_strb = 4'h0; rw_addr = 16'h0;
  endtask

  task automatic reg_rd(input logic [15:0] a, output logic [31:0] d);
    settled = 1'b0;
    @(negedge clk);
    rw_addr = a; rd_en = 1'b1;
    #1 d = rd_data;
    @(negedge clk);
    rd_en = 1'b0; rw_addr = 16'h0;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    reg_rd(a, d);
    check(name, d, exp);
    if (a == A_DATA) m_rxv = 1'b0;
    settle();
  endtask

  task automatic set_mode(input logic [1:0] m);
    reg_wr(A_MODE, {30'd0, m});
    m_cpha = m[0]; m_cpol = m[1];
    settle();
  endtask

  task automatic wr_tx(input logic [7:0] v);
    reg_wr(A_DATA, {24'd0, v});
    m_tx = v; m_tx_full = 1'b1;
    settle();
  endtask

  // Master side of one frame: nbits bits MSB-first from mw, MISO collected in got
  task automatic spi_frame(input int nbits, input logic [15:0] mw, input bit chk,
                           output logic [15:0] got);
    logic samp;
    got = 16'h0;
    spi_sck = m_cpol; spi_cs_n = 1'b1;
    wait_clk(4);
    spi_cs_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      if (!m_cpha) begin
        spi_mosi = mw[15-i];
        wait_clk(H/2);
        spi_sck = ~m_cpol;
      end else begin
        spi_sck = ~m_cpol;
        wait_clk(H/2);
        spi_mosi = mw[15-i];
        wait_clk(H/2);
        spi_sck = m_cpol;
      end
      samp = spi_miso;
      got  = {got[14:0], samp};
      wait_clk(H-1);
      if (chk) check("miso_stable", {31'd0, spi_miso}, {31'd0, samp});
      wait_clk(1);
      if (!m_cpha) begin
        spi_sck = m_cpol;
        wait_clk(H/2);
      end
    end
    wait_clk(H);
    spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wait_clk(H);
  endtask

  // Every byte the master touches takes the pending DATA byte or 0x00 with
  // underrun; every complete byte lands in rx, overrunning an unread one.
  task automatic model_frame(input int nbits, input logic [15:0] mw, output logic [15:0] ew);
    ew = 16'h0;
    for (int k = 0; k < 2; k++) begin
      if (nbits > 8*k) begin
        if (m_tx_full) ew[15-8*k -: 8] = m_tx;
        else m_udr = 1'b1;
        m_tx_full = 1'b0;
      end
    end
    for (int k = 0; k < nbits/8; k++) begin
      if (m_rxv) m_ovr = 1'b1;
      m_rx  = mw[15-8*k -: 8];
      m_rxv = 1'b1;
    end
  endtask

  task automatic run_frame(input int nbits, input logic [15:0] mw, input string name,
                           output logic [15:0] got);
    logic [15:0] ew;
    settled = 1'b0;
    model_frame(nbits, mw, ew);
    spi_frame(nbits, mw, 1'b1, got);
    check(name, {16'd0, got}, {16'd0, ew >> (16 - nbits)});
    settle();
  endtask

  task automatic model_reset();
    m_cpol = 0; m_cpha = 0; m_tx_full = 0; m_rxv = 0; m_ovr = 0; m_udr = 0;
    m_tx = 8'h0; m_rx = 8'h0; m_ie = 4'h0;
  endtask

  initial begin
    #(500000);
    $display("FAIL watchdog: time limit reached, got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [31:0] d;
    model_reset();
    wait_clk(4);
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_outputs", {29'd0, irq, spi_miso_oe, spi_miso}, 32'h0);
    rd_chk(A_CTRL, 32'h0, "rst_ctrl");
    rd_chk(A_MODE, 32'h0, "rst_mode");
    rd_chk(A_STATUS, 32'h2, "rst_status");
    rd_chk(A_DATA, 32'h0, "rst_data");
    rd_chk(16'h0004, 32'h0, "unmapped");
    rw_addr = A_STATUS;
    #1 check("rd_en_low", rd_data, 32'h0);
    rw_addr = 16'h0;

    // Mode 0 single byte
    reg_wr(A_CTRL, 32'h1);
    reg_wr(A_IE, 32'h1); m_ie = 4'h1;
    set_mode(2'd0);
    wr_tx(8'hA5);
    run_frame(8, 16'h3C00, "m0_miso", got);
    check("m0_miso_lit", {16'd0, got}, 32'hA5);
    check("m0_irq", {31'd0, irq}, 32'h1);
    rd_chk(A_STATUS, 32'h03, "m0_status");
    rd_chk(A_DATA, 32'h3C, "m0_rx");
    rd_chk(A_STATUS, 32'h02, "m0_status_after_rd");
    check("m0_irq_clear", {31'd0, irq}, 32'h0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1:0]);
      wr_tx(8'h81);
      run_frame(8, 16'h7E00, $sformatf("mode%0d_miso", m), got);
      check($sformatf("mode%0d_miso_lit", m), {16'd0, got}, 32'h81);
      rd_chk(A_STATUS, m_status(), $sformatf("mode%0d_status", m));
      rd_chk(A_DATA, 32'h7E, $sformatf("mode%0d_rx", m));
    end

    // Two-byte frame, one DATA write, no read in between
    reg_wr(A_IE, 32'hD); m_ie = 4'hD;
    set_mode(2'd0);
    wr_tx(8'h55);
    run_frame(16, 16'h1122, "two_miso", got);
    check("two_miso_lit", {16'd0, got}, 32'h5500);
    rd_chk(A_STATUS, 32'h0F, "two_status");
    reg_wr(A_STATUS, 32'h8); m_udr = 1'b0; settle();
    rd_chk(A_STATUS, 32'h07, "udr_w1c");
    rd_chk(A_DATA, 32'h22, "two_rx");
    rd_chk(A_STATUS, 32'h06, "ovr_kept_after_rd");
    reg_wr(A_STATUS, 32'h4); m_ovr = 1'b0; settle();
    rd_chk(A_STATUS, 32'h02, "ovr_w1c");

    // CS deasserted after 5 bits, then a full frame
    wr_tx(8'h99);
    run_frame(5, 16'hA800, "part_miso", got);
    check("part_miso_lit", {16'd0, got}, 32'h13);
    rd_chk(A_STATUS, 32'h02, "part_status");
    wr_tx(8'h5A);
    run_frame(8, 16'hC300, "after_part_miso", got);
    check("after_part_miso_lit", {16'd0, got}, 32'h5A);
    rd_chk(A_DATA, 32'hC3, "after_part_rx");

    // MODE write while busy, then reset mid-frame
    settled = 1'b0;
    fork
      spi_frame(16, 16'hFFFF, 1'b0, got);
      begin
        wait_clk(40);
        reg_wr(A_MODE, 32'h3);
        reg_rd(A_MODE, d);
        check("mode_busy_ignored", d, 32'h0);
        reg_rd(A_STATUS, d);
        check("busy_bit", d & 32'h10, 32'h10);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {29'd0, irq, spi_miso_oe, spi_miso}, 32'h0);
        @(negedge clk) rst = 1'b0;
      end
    join
    model_reset();
    settle();
    rd_chk(A_CTRL, 32'h0, "rst2_ctrl");
    rd_chk(A_MODE, 32'h0, "rst2_mode");
    rd_chk(A_IE, 32'h0, "rst2_ie");
    rd_chk(A_STATUS, 32'h02, "rst2_status");
    rd_chk(A_DATA, 32'h0, "rst2_data");

    // Recovery after reset
    reg_wr(A_CTRL, 32'h1);
    set_mode(2'd3);
    wr_tx(8'hE7);
    run_frame(8, 16'h1800, "recover_miso", got);
    rd_chk(A_DATA, 32'h18, "recover_rx");

    settled = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
Memory-mapped SPI slave (responder) peripheral. It is the counterpart to the team's SPI master and has the same register-bus style.
- Oversamples an external master's SCK, CS_N and MOSI in the system clock domain, then shifts 8-bit frames in and out, MSB first, in all four CPOL/CPHA modes.
- The CPU reaches it through the same word-addressed register interface as the other peripherals, and it drives a level irq.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on spi_sck/spi_cs_n/spi_mosi (min 2)

Ports:
clk  input  1  system clock; the single clock for all logic
rst  input  1  reset, synchronous, active-high
rw_addr  input  16  register byte address
wr_en  input  1  register write enable
wr_data  input  32  write data
wr_strb  input  4  byte strobes; writes accepted only when 4'b1111
rd_en  input  1  register read enable
rd_data  output  32  combinational read mux; 0 for unmapped addresses or rd_en=0
spi_sck  input  1  SPI clock from master, asynchronous
spi_cs_n  input  1  slave select, active low, asynchronous
spi_mosi  input  1  serial data in
spi_miso  output  1  serial data out
spi_miso_oe  output  1  MISO output enable (1 while selected and enabled)
irq  output  1  registered, active-high, level interrupt

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, irq=0; all registers and flags 0; FSM in IDLE. Reset mid-frame aborts immediately; partial byte discarded.
- Register map:
  - 0x00 CTRL: bit0 en.
  - 0x08 MODE: bit0 CPHA, bit1 CPOL. Writes are ignored while busy.
  - 0x0C STATUS: bit0 rx_valid, bit1 tx_empty (=~tx_full), bit2 rx_overrun, bit3 tx_underrun, bit4 busy. Bits 2-3 are write-1-to-clear.
  - 0x10 DATA: a write sets tx_reg=wr_data[7:0], tx_full=1 (overwrites silently). A read returns {24'd0, rx_reg} and clears rx_valid.
  - 0x14 IE: bits 3:0 mask STATUS 3:0.
- irq <= |(status[3:0] & ie[3:0]), i.e. one-cycle registered.
- Input path: SYNC_STAGES flops plus one history flop per input. Edge detection compares the last two synchronised samples. Pin-to-event latency is SYNC_STAGES+1 clk.
- Required ratio: f_clk >= 8 * f_sck.
- Edge roles:
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other.
- FSM IDLE:
  - spi_miso_oe=0; bit_cnt=0.
  - On a synchronised cs_n falling edge with en=1 → XFER, busy=1.
  - If CPHA=0, the tx load happens here.
- FSM XFER:
  - spi_miso_oe=1.
  - Sample edge: shift_rx <= {shift_rx[6:0], mosi}; bit_cnt++.
  - When bit_cnt wraps 7→0: rx_reg<=byte, rx_valid=1, and rx_overrun=1 if rx_valid was already 1 and not being read that cycle.
  - Shift edge with bit_cnt==0: tx load. Shift edge otherwise: shift_tx <<= 1.
  - spi_miso = shift_tx[7] at all times in XFER.
- Tx load: if tx_full, shift_tx<=tx_reg and tx_full<=0. Otherwise shift_tx<=8'h00 and tx_underrun<=1.
- Multi-byte frames: CS held low continues byte after byte; bit_cnt wraps.
- CS deassert (synchronised rising edge) → IDLE, in any bit position. A partial byte sets no flags.
- en cleared mid-frame: behaves as CS deassert.
- SCK edges while cs_n is high are ignored.
- Simultaneous events:
  - Byte completion and DATA read in the same clk: new byte stored, rx_valid stays 1, no overrun.
  - DATA write and tx load in the same clk: the load takes the old content (or 0x00 with underrun), then tx_reg=new and tx_full=1.
  - W1C and a set in the same clk: the set wins.

Decomposition:
- Shared include spi_slave_defs: register offsets, STATUS/IE bit indices, FSM state encodings.
- Sub-module spi_slave_sync: synchroniser chain plus rise/fall pulse outputs, instantiated once per input (×3).

Test Plan:
- Mode 0, en=1, DATA←0xA5, master sends 0x3C → master reads 0xA5 on MISO; rx_reg=0x3C; STATUS=0x03 then 0x02 after DATA read; irq high 1 clk after rx_valid when IE=0x1.
- Modes 1/2/3 each: DATA←0x81, master sends 0x7E → exchange correct; MISO changes only on shift edges.
- 2-byte frame with only one DATA write (0x55) → MISO bytes 0x55, 0x00; tx_underrun=1; write STATUS 0x8 clears it.
- Two bytes received (0x11, 0x22) with no read → rx_reg=0x22, rx_overrun=1; a read returns 0x22 and clears rx_valid only.
- CS deasserted after 5 bits → rx_valid stays 0, busy=0, miso_oe=0; the next full frame is received correctly from bit 0.
- rst asserted mid-frame → all outputs 0, registers reset; MODE write during busy ignored (read back unchanged).
